meas_ctrl: RTL

MEAS_CTRL -- requirements
Module: meas_ctrl

---
 rtl/meas_pkg.sv | 18 +
 rtl/meas_stats.sv | 34 +++
 rtl/meas_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement controller.
package meas_pkg;

  localparam int unsigned SAMPLE_W           = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;
  localparam int unsigned N_STATES           = 6;

  // Bit positions of the one-hot state vector
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_ABORT     = 3'd4,
    S_DONE      = 3'd5
  } state_idx_e;

endpackage

// File: rtl/meas_stats.sv
// Accumulate / min / max datapath for one batch of counter samples.
module meas_stats
  import meas_pkg::*;
#(
  parameter int unsigned SUM_W = SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                ld,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SUM_W-1:0]    sum,
  output logic [SAMPLE_W-1:0] min_val,
  output logic [SAMPLE_W-1:0] max_val
);

  // Clear seeds min high and max low so the first sample wins both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      min_val <= '0;
      max_val <= '0;
    end else if (clr) begin
      sum     <= '0;
      min_val <= '1;
      max_val <= '0;
    end else if (ld) begin
      sum <= sum + SUM_W'(sample);
      if (sample < min_val) min_val <= sample;
      if (sample > max_val) max_val <= sample;
    end
  end

endmodule

// File: rtl/meas_ctrl.sv
// Batch measurement controller: issues 2^LOG2_SAMPLES counter runs and
// reports sum/avg/min/max. Optional timeout/abort: MEAS_CTRL_TIMEOUT_EN.
module meas_ctrl
  import meas_pkg::*;
#(
  parameter int unsigned LOG2_SAMPLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             go,
  output logic                             cnt_start,
  input  logic                             cnt_busy,
  input  logic [SAMPLE_W-1:0]              cnt_val,
  output logic                             cnt_rst_n,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [SAMPLE_W+LOG2_SAMPLES-1:0] sum,
  output logic [SAMPLE_W-1:0]              avg,
  output logic [SAMPLE_W-1:0]              min_val,
  output logic [SAMPLE_W-1:0]              max_val
);

  localparam int unsigned SUM_W     = SAMPLE_W + LOG2_SAMPLES;
  localparam int unsigned IDX_W     = LOG2_SAMPLES + 1;
  localparam int unsigned N_SAMPLES = 1 << LOG2_SAMPLES;

  logic [N_STATES-1:0] state;
  logic [N_STATES-1:0] state_nxt;
  logic [IDX_W-1:0]    idx;
  logic                clr_c;
  logic                ld_c;
  logic                last_c;
  logic                timeout_c;

  assign last_c = (idx == IDX_W'(N_SAMPLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= '0;
      state[S_IDLE] <= 1'b1;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; an empty or corrupted vector falls back to IDLE
  always_comb begin
    state_nxt = '0;
    clr_c     = 1'b0;
    ld_c      = 1'b0;
    if (state[S_IDLE]) begin
      if (go) begin
        clr_c              = 1'b1;
        state_nxt[S_ISSUE] = 1'b1;
      end else begin
        state_nxt[S_IDLE] = 1'b1;
      end
    end else if (state[S_ISSUE]) begin
      state_nxt[S_WAIT_BUSY] = 1'b1;
    end else if (state[S_WAIT_BUSY]) begin
      if (cnt_busy)       state_nxt[S_WAIT_IDLE] = 1'b1;
      else if (timeout_c) state_nxt[S_ABORT]     = 1'b1;
      else                state_nxt[S_WAIT_BUSY] = 1'b1;
    end else if (state[S_WAIT_IDLE]) begin
      if (!cnt_busy) begin
        ld_c = 1'b1;
        if (last_c) state_nxt[S_DONE]  = 1'b1;
        else        state_nxt[S_ISSUE] = 1'b1;
      end else if (timeout_c) begin
        state_nxt[S_ABORT] = 1'b1;
      end else begin
        state_nxt[S_WAIT_IDLE] = 1'b1;
      end
    end else if (state[S_ABORT]) begin
      state_nxt[S_DONE] = 1'b1;
    end else begin
      state_nxt[S_IDLE] = 1'b1;
    end
  end

  // Registered outputs aligned with the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_start <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      avg       <= '0;
    end else begin
      cnt_start <= state_nxt[S_ISSUE];
      done      <= state_nxt[S_DONE];
      busy      <= !state_nxt[S_IDLE];
      if (clr_c)     idx <= '0;
      else if (ld_c) idx <= idx + IDX_W'(1);
      if (state[S_DONE]) avg <= SAMPLE_W'(sum >> LOG2_SAMPLES);
    end
  end

`ifdef MEAS_CTRL_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr;

  assign timeout_c = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  // Per-measurement watchdog; abort pulses the counter's soft reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr       <= '0;
      err       <= 1'b0;
      cnt_rst_n <= 1'b1;
    end else begin
      if (state[S_ISSUE])                             tmr <= '0;
      else if (state[S_WAIT_BUSY] || state[S_WAIT_IDLE]) tmr <= tmr + TMR_W'(1);
      cnt_rst_n <= !state_nxt[S_ABORT];
      if (clr_c)                   err <= 1'b0;
      else if (state_nxt[S_ABORT]) err <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign cnt_rst_n = 1'b1;
  assign err       = 1'b0;
`endif

  meas_stats #(
    .SUM_W (SUM_W)
  ) u_stats (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .ld      (ld_c),
    .sample  (cnt_val),
    .sum     (sum),
    .min_val (min_val),
    .max_val (max_val)
  );

endmodule
